// File: rtl/chip8_pkg.sv
// Shared Chip-8 display constants and the sprite draw FSM state encoding.
package chip8_pkg;

    localparam int SCR_W            = 64;
    localparam int SCR_H            = 32;
    localparam int FB_BYTES_PER_ROW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MWAIT,
        ST_RDL,
        ST_WRL,
        ST_RDR,
        ST_WRR,
        ST_DONE
    } sprite_state_t;

endpackage

// File: rtl/sprite_shift.sv
// Splits a sprite byte shifted right by the pixel offset into the bytes
// landing in the left and right framebuffer columns.
module sprite_shift (
    input  logic [7:0] byte_in,
    input  logic [2:0] shamt,
    output logic [7:0] s_left,
    output logic [7:0] s_right
);

    logic [15:0] s;

    always_comb begin
        s       = {byte_in, 8'h00} >> shamt;
        s_left  = s[15:8];
        s_right = s[7:0];
    end

endmodule

// File: rtl/sprite_draw.sv
// Chip-8 DXYN executor: fetches sprite rows from CPU memory and XORs them
// into the 64x32 byte-packed framebuffer, tracking the VF collision flag.
module sprite_draw
    import chip8_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int FB_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        x,
    input  logic [4:0]        y,
    input  logic [3:0]        n,
    input  logic [MEM_AW-1:0] i_addr,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              fb_en,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [7:0]        fb_wdata,
    input  logic [7:0]        fb_rdata
);

    sprite_state_t     state_q, state_d;
    logic [5:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic [3:0]        n_q, n_d;
    logic [MEM_AW-1:0] i_addr_q, i_addr_d;
    logic [3:0]        r_q, r_d;
    logic [7:0]        byte_q, byte_d;
    logic              collision_q, collision_d;

    logic [7:0] s_left, s_right;
    logic [4:0] row;
    logic [2:0] col_l, col_r;
    logic [3:0] r_next;

    sprite_shift u_shift (
        .byte_in (byte_q),
        .shamt   (x_q[2:0]),
        .s_left  (s_left),
        .s_right (s_right)
    );

    // Row and column both wrap naturally through their truncated widths.
    assign row    = y_q + {1'b0, r_q};
    assign col_l  = x_q[5:3];
    assign col_r  = col_l + 3'd1;
    assign r_next = r_q + 4'd1;

    assign collision = collision_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        i_addr_d    = i_addr_q;
        r_d         = r_q;
        byte_d      = byte_q;
        collision_d = collision_q;
        busy        = 1'b1;
        done        = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;
        fb_en       = 1'b0;
        fb_we       = 1'b0;
        fb_addr     = '0;
        fb_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    x_d         = x;
                    y_d         = y;
                    n_d         = n;
                    i_addr_d    = i_addr;
                    r_d         = '0;
                    collision_d = 1'b0;
                    state_d     = (n == 4'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = i_addr_q + MEM_AW'(r_q);
                state_d  = ST_MWAIT;
            end
            ST_MWAIT: begin
                byte_d  = mem_rdata;
                state_d = ST_RDL;
            end
            ST_RDL: begin
                fb_en   = 1'b1;
                fb_addr = {row, col_l};
                state_d = ST_WRL;
            end
            ST_WRL: begin
                fb_en       = 1'b1;
                fb_we       = 1'b1;
                fb_addr     = {row, col_l};
                fb_wdata    = fb_rdata ^ s_left;
                collision_d = collision_q | (|(fb_rdata & s_left));
                if (x_q[2:0] != 3'd0) begin
                    state_d = ST_RDR;
                end else begin
                    r_d     = r_next;
                    state_d = (r_next == n_q) ? ST_DONE : ST_FETCH;
                end
            end
            ST_RDR: begin
                fb_en   = 1'b1;
                fb_addr = {row, col_r};
                state_d = ST_WRR;
            end
            ST_WRR: begin
                fb_en       = 1'b1;
                fb_we       = 1'b1;
                fb_addr     = {row, col_r};
                fb_wdata    = fb_rdata ^ s_right;
                collision_d = collision_q | (|(fb_rdata & s_right));
                r_d         = r_next;
                state_d     = (r_next == n_q) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= '0;
            i_addr_q    <= '0;
            r_q         <= '0;
            byte_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            n_q         <= n_d;
            i_addr_q    <= i_addr_d;
            r_q         <= r_d;
            byte_q      <= byte_d;
            collision_q <= collision_d;
        end
    end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw with behavioural CPU memory and framebuffer.
module tb_sprite_draw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  x = '0;
    logic [4:0]  y = '0;
    logic [3:0]  n = '0;
    logic [11:0] i_addr = '0;
    logic        busy, done, collision;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        fb_en, fb_we;
    logic [7:0]  fb_addr, fb_wdata;
    logic [7:0]  fb_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:4095];
    logic [7:0] fb  [0:255];
    logic       fb_clr = 1'b0;
    logic       cnt_clr = 1'b0;
    int         n_mem = 0, n_fbr = 0, n_fbw = 0, n_bad = 0, n_done = 0;

    int   lat;
    logic coll;

    always #5 clk = ~clk;

    sprite_draw #(.MEM_AW(12), .FB_AW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .y         (y),
        .n         (n),
        .i_addr    (i_addr),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .fb_en     (fb_en),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .fb_rdata  (fb_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        if (fb_clr) begin
            for (int i = 0; i < 256; i++) fb[i] <= 8'h00;
        end else if (fb_en) begin
            if (fb_we) fb[fb_addr] <= fb_wdata;
            else       fb_rdata <= fb[fb_addr];
        end
        if (cnt_clr) begin
            n_mem <= 0; n_fbr <= 0; n_fbw <= 0; n_bad <= 0; n_done <= 0;
        end else begin
            if (mem_en)           n_mem  <= n_mem + 1;
            if (fb_en && !fb_we)  n_fbr  <= n_fbr + 1;
            if (fb_en && fb_we)   n_fbw  <= n_fbw + 1;
            if ((mem_en && fb_en) || (fb_we && !fb_en)) n_bad <= n_bad + 1;
            if (done)             n_done <= n_done + 1;
        end
    end

    task automatic clear_env;
        @(negedge clk); fb_clr = 1'b1; cnt_clr = 1'b1;
        @(negedge clk); fb_clr = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_counters;
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    // Returns the cycle count from the start cycle to the done cycle (-1 on timeout).
    task automatic run_draw(input logic [5:0] xx, input logic [4:0] yy, input logic [3:0] nn,
                            input logic [11:0] ii, output int l, output logic c);
        @(negedge clk);
        x = xx; y = yy; n = nn; i_addr = ii; start = 1'b1;
        l = -1; c = 1'bx;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                l = k; c = collision;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, collision, mem_en, fb_en, fb_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {busy, done, collision, mem_en, fb_en, fb_we});
        end
        checks++;
        if ({mem_addr, fb_addr, fb_wdata} !== 28'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 0", {mem_addr, fb_addr, fb_wdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned;
        clear_env();
        run_draw(6'd8, 5'd0, 4'd1, 12'h000, lat, coll);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL aligned_latency: got %0d expected 5", lat); end
        checks++;
        if (fb[1] !== 8'hF0) begin errors++; $display("FAIL aligned_fb1: got %h expected f0", fb[1]); end
        checks++;
        if (coll !== 1'b0) begin errors++; $display("FAIL aligned_collision: got %b expected 0", coll); end
    endtask

    task automatic test_redraw;
        clear_counters();
        run_draw(6'd8, 5'd0, 4'd1, 12'h000, lat, coll);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL redraw_latency: got %0d expected 5", lat); end
        checks++;
        if (fb[1] !== 8'h00) begin errors++; $display("FAIL redraw_fb1: got %h expected 00", fb[1]); end
        checks++;
        if (coll !== 1'b1) begin errors++; $display("FAIL redraw_collision: got %b expected 1", coll); end
        checks++;
        if ({n_mem, n_fbr, n_fbw} !== {32'd1, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL redraw_access_counts: got mem=%0d rd=%0d wr=%0d expected 1 1 1", n_mem, n_fbr, n_fbw);
        end
        checks++;
        if (n_bad !== 0) begin errors++; $display("FAIL redraw_port_exclusive: got %0d expected 0", n_bad); end
    endtask

    task automatic test_n_zero;
        clear_counters();
        run_draw(6'd3, 5'd0, 4'd0, 12'h000, lat, coll);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL nzero_latency: got %0d expected 1", lat); end
        checks++;
        if (coll !== 1'b0) begin errors++; $display("FAIL nzero_collision: got %b expected 0", coll); end
        checks++;
        if ((n_mem + n_fbr + n_fbw) !== 0) begin
            errors++;
            $display("FAIL nzero_no_access: got %0d accesses expected 0", n_mem + n_fbr + n_fbw);
        end
    endtask

    task automatic test_unaligned_wrap;
        clear_env();
        run_draw(6'd60, 5'd31, 4'd2, 12'h300, lat, coll);
        checks++;
        if (lat !== 13) begin errors++; $display("FAIL wrap_latency: got %0d expected 13", lat); end
        checks++;
        if (fb[255] !== 8'h0F) begin errors++; $display("FAIL wrap_fb255: got %h expected 0f", fb[255]); end
        checks++;
        if (fb[248] !== 8'hF0) begin errors++; $display("FAIL wrap_fb248: got %h expected f0", fb[248]); end
        checks++;
        if (fb[7] !== 8'h08) begin errors++; $display("FAIL wrap_fb7: got %h expected 08", fb[7]); end
        checks++;
        if (fb[0] !== 8'h10) begin errors++; $display("FAIL wrap_fb0: got %h expected 10", fb[0]); end
        checks++;
        if (coll !== 1'b0) begin errors++; $display("FAIL wrap_collision: got %b expected 0", coll); end
        checks++;
        if ({n_mem, n_fbr, n_fbw, n_bad} !== {32'd2, 32'd4, 32'd4, 32'd0}) begin
            errors++;
            $display("FAIL wrap_access_counts: got mem=%0d rd=%0d wr=%0d bad=%0d expected 2 4 4 0",
                     n_mem, n_fbr, n_fbw, n_bad);
        end
    endtask

    task automatic test_busy_ignore;
        clear_env();
        @(negedge clk);
        x = 6'd0; y = 5'd2; n = 4'd1; i_addr = 12'h000; start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                x = 6'd16; y = 5'd5; n = 4'd3; i_addr = 12'h300; start = 1'b1;
            end
            if (done) begin lat = k; coll = collision; break; end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL busy_latency: got %0d expected 5", lat); end
        checks++;
        if (fb[16] !== 8'hF0) begin errors++; $display("FAIL busy_fb16: got %h expected f0", fb[16]); end
        checks++;
        if (fb[42] !== 8'h00) begin errors++; $display("FAIL busy_fb42_untouched: got %h expected 00", fb[42]); end
        checks++;
        if ({busy, n_done} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL busy_single_draw: got busy=%b dones=%0d expected 0 1", busy, n_done);
        end
    endtask

    task automatic test_reset_mid;
        logic found;
        clear_env();
        mem[12'h302] = 8'h3C;
        mem[12'h303] = 8'h55;
        @(negedge clk);
        x = 6'd0; y = 5'd10; n = 4'd4; i_addr = 12'h300; start = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (fb_we && fb_addr == 8'd88) begin found = 1'b1; break; end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL midreset_reach_wrl: got %b expected 1", found); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, collision, mem_en, fb_en, fb_we} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 000000", {busy, done, collision, mem_en, fb_en, fb_we});
        end
        checks++;
        if ({mem_addr, fb_addr, fb_wdata} !== 28'h0) begin
            errors++;
            $display("FAIL midreset_buses: got %h expected 0", {mem_addr, fb_addr, fb_wdata});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", n_done); end
        checks++;
        if ({fb[80], fb[88], fb[96]} !== 24'hFF_81_00) begin
            errors++;
            $display("FAIL midreset_fb_rows: got %h %h %h expected ff 81 00", fb[80], fb[88], fb[96]);
        end
    endtask

    task automatic test_after_reset;
        run_draw(6'd0, 5'd20, 4'd1, 12'h000, lat, coll);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL after_reset_latency: got %0d expected 5", lat); end
        checks++;
        if (fb[160] !== 8'hF0) begin errors++; $display("FAIL after_reset_fb160: got %h expected f0", fb[160]); end
        checks++;
        if (coll !== 1'b0) begin errors++; $display("FAIL after_reset_collision: got %b expected 0", coll); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'hF0;
        mem[12'h300] = 8'hFF;
        mem[12'h301] = 8'h81;
        test_reset();
        test_aligned();
        test_redraw();
        test_n_zero();
        test_unaligned_wrap();
        test_busy_ignore();
        test_reset_mid();
        test_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
